// File: rtl/pc_ctx_pkg.sv
// Shared constants for the context-switching program counter: FSM state
// encodings, default entry addresses and the quantum counter width.
package pc_ctx_pkg;

    localparam int unsigned QCNT_W  = 12;
    localparam int unsigned STATE_W = 2;

    localparam logic [1:0] RUN         = 2'd0;
    localparam logic [1:0] HALTED      = 2'd1;
    localparam logic [1:0] SWITCH_WAIT = 2'd2;

    localparam int unsigned DEF_SCHED_ADDR = 427;
    localparam int unsigned DEF_MENU_ADDR  = 34;
    localparam int unsigned DEF_IRQ_VECTOR = 0;

endpackage

// File: rtl/pc_ctx_table.sv
// Per-process saved-PC table: one synchronous write port, one combinational
// read port, valid bits cleared by synchronous reset or an explicit clear.
module pc_ctx_table #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned NUM_PROC = 4,
    parameter int unsigned PID_W    = 2
) (
    input  logic              ck,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [PID_W-1:0]  wr_pid_i,
    input  logic [ADDR_W-1:0] wr_pc_i,
    input  logic              clr_en_i,
    input  logic [PID_W-1:0]  clr_pid_i,
    input  logic [PID_W-1:0]  rd_pid_i,
    output logic [ADDR_W-1:0] rd_pc_c,
    output logic              rd_valid_c
);

    logic [ADDR_W-1:0]   pc_q [NUM_PROC];
    logic [NUM_PROC-1:0] valid_q;

    // A save to the same pid in the same cycle overrides a clear.
    always_ff @(posedge ck) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (clr_en_i) valid_q[clr_pid_i] <= 1'b0;
            if (wr_en_i)  valid_q[wr_pid_i]  <= 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (wr_en_i) pc_q[wr_pid_i] <= wr_pc_i;
    end

    assign rd_pc_c    = pc_q[rd_pid_i];
    assign rd_valid_c = valid_q[rd_pid_i];

endmodule

// File: rtl/pc_ctx_sequencer.sv
// Program counter with interrupt/eret, halt/resume and time-sliced context
// switching. Optional macro PC_CTX_CLEAR_EN adds ctx_clear/clear_pid ports.
module pc_ctx_sequencer
    import pc_ctx_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned NUM_PROC   = 4,
    parameter int unsigned PID_W      = 2,
    parameter int unsigned QUANTUM    = 50,
    parameter int unsigned SCHED_ADDR = DEF_SCHED_ADDR,
    parameter int unsigned MENU_ADDR  = DEF_MENU_ADDR,
    parameter int unsigned IRQ_VECTOR = DEF_IRQ_VECTOR
) (
    input  logic              ck,
    input  logic              reset,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              irq,
    input  logic              eret,
    input  logic              return_menu,
    input  logic              halt,
    input  logic              resume,
    input  logic              switch_ack,
    input  logic [PID_W-1:0]  next_pid,
`ifdef PC_CTX_CLEAR_EN
    input  logic              ctx_clear,
    input  logic [PID_W-1:0]  clear_pid,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic [PID_W-1:0]  cur_pid,
    output logic              switch_req,
    output logic              kernel_mode,
    output logic [QCNT_W-1:0] quantum_cnt,
    output logic              halted
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, epc_q, epc_d;
    logic [PID_W-1:0]   pid_q, pid_d;
    logic               sreq_q, sreq_d, kern_q, kern_d, halted_q, halted_d, resume_q;
    logic [QCNT_W-1:0]  qcnt_q, qcnt_d;

    logic [ADDR_W-1:0]  pc_inc;
    logic               wr_en_c;
    logic [ADDR_W-1:0]  rd_pc_c;
    logic               rd_valid_c;
    logic               clr_en;
    logic [PID_W-1:0]   clr_pid;

`ifdef PC_CTX_CLEAR_EN
    assign clr_en  = ctx_clear;
    assign clr_pid = clear_pid;
`else
    assign clr_en  = 1'b0;
    assign clr_pid = '0;
`endif

    assign pc_inc = pc_q + ADDR_W'(1);

    pc_ctx_table #(
        .ADDR_W   (ADDR_W),
        .NUM_PROC (NUM_PROC),
        .PID_W    (PID_W)
    ) u_table (
        .ck         (ck),
        .reset      (reset),
        .wr_en_i    (wr_en_c),
        .wr_pid_i   (pid_q),
        .wr_pc_i    (pc_inc),
        .clr_en_i   (clr_en),
        .clr_pid_i  (clr_pid),
        .rd_pid_i   (next_pid),
        .rd_pc_c    (rd_pc_c),
        .rd_valid_c (rd_valid_c)
    );

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= '0;
            epc_q    <= '0;
            pid_q    <= '0;
            sreq_q   <= 1'b0;
            kern_q   <= 1'b0;
            qcnt_q   <= '0;
            halted_q <= 1'b0;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            pid_q    <= pid_d;
            sreq_q   <= sreq_d;
            kern_q   <= kern_d;
            qcnt_q   <= qcnt_d;
            halted_q <= halted_d;
            resume_q <= resume;
        end
    end

    // Next-PC arbitration; one action per cycle in priority order.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        pid_d   = pid_q;
        sreq_d  = sreq_q;
        kern_d  = kern_q;
        qcnt_d  = qcnt_q;
        wr_en_c = 1'b0;

        case (state_q)
            RUN: begin
                if (!kern_q) qcnt_d = qcnt_q + QCNT_W'(1);
                if (irq && !kern_q) begin
                    epc_d  = pc_inc;
                    pc_d   = ADDR_W'(IRQ_VECTOR);
                    kern_d = 1'b1;
                end else if (eret && kern_q) begin
                    pc_d   = epc_q;
                    kern_d = 1'b0;
                end else if (qcnt_q >= QCNT_W'(QUANTUM - 1) && !kern_q) begin
                    // >= so an expiry deferred by an interrupt still fires after eret.
                    wr_en_c = 1'b1;
                    sreq_d  = 1'b1;
                    state_d = SWITCH_WAIT;
                end else if (jump) begin
                    pc_d = jump_addr;
                end else if (return_menu) begin
                    pc_d = ADDR_W'(MENU_ADDR);
                end else if (halt) begin
                    state_d = HALTED;
                end else begin
                    pc_d = pc_inc;
                end
            end
            HALTED: begin
                if (irq && !kern_q) begin
                    epc_d   = pc_inc;
                    pc_d    = ADDR_W'(IRQ_VECTOR);
                    kern_d  = 1'b1;
                    state_d = RUN;
                end else if (resume && !resume_q) begin
                    pc_d    = pc_inc;
                    state_d = RUN;
                end
            end
            SWITCH_WAIT: begin
                if (switch_ack) begin
                    sreq_d  = 1'b0;
                    pid_d   = next_pid;
                    qcnt_d  = '0;
                    pc_d    = rd_valid_c ? rd_pc_c : ADDR_W'(SCHED_ADDR);
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        halted_d = (state_d == HALTED);
    end

    assign pc          = pc_q;
    assign cur_pid     = pid_q;
    assign switch_req  = sreq_q;
    assign kernel_mode = kern_q;
    assign quantum_cnt = qcnt_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_ctx_sequencer.sv
// Scenario bench for pc_ctx_sequencer with default parameters; expected PCs
// are queued when stimulus is applied and popped after each clock edge.
module tb_pc_ctx_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned PW = 2;

    logic          ck = 1'b0;
    logic          reset, jump, irq, eret, return_menu, halt, resume, switch_ack;
    logic [AW-1:0] jump_addr;
    logic [PW-1:0] next_pid;
`ifdef PC_CTX_CLEAR_EN
    logic          ctx_clear;
    logic [PW-1:0] clear_pid;
`endif
    logic [AW-1:0] pc;
    logic [PW-1:0] cur_pid;
    logic          switch_req, kernel_mode, halted;
    logic [11:0]   quantum_cnt;

    typedef struct {
        string         tag;
        logic [AW-1:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 ck = ~ck;

    pc_ctx_sequencer dut (
        .ck          (ck),
        .reset       (reset),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .irq         (irq),
        .eret        (eret),
        .return_menu (return_menu),
        .halt        (halt),
        .resume      (resume),
        .switch_ack  (switch_ack),
        .next_pid    (next_pid),
`ifdef PC_CTX_CLEAR_EN
        .ctx_clear   (ctx_clear),
        .clear_pid   (clear_pid),
`endif
        .pc          (pc),
        .cur_pid     (cur_pid),
        .switch_req  (switch_req),
        .kernel_mode (kernel_mode),
        .quantum_cnt (quantum_cnt),
        .halted      (halted)
    );

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; jump = 1'b0; jump_addr = '0; irq = 1'b0; eret = 1'b0;
        return_menu = 1'b0; halt = 1'b0; resume = 1'b0; switch_ack = 1'b0; next_pid = '0;
`ifdef PC_CTX_CLEAR_EN
        ctx_clear = 1'b0; clear_pid = '0;
`endif
        tick();
        tick();
        n_cmp++;
        if ({pc, cur_pid, switch_req, kernel_mode, quantum_cnt, halted} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: pc=%0d pid=%0d sreq=%0b kern=%0b qc=%0d halted=%0b, required all zero",
                     pc, cur_pid, switch_req, kernel_mode, quantum_cnt, halted);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        exp_t e;
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back('{"idle_pc", AW'(k)});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc) begin
                n_err++;
                $display("FAIL %s: got %0d want %0d", e.tag, pc, e.pc);
            end
        end
        n_cmp++;
        if (quantum_cnt !== 12'd5 || switch_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle_qc: qc=%0d sreq=%0b want qc=5 sreq=0", quantum_cnt, switch_req);
        end
    endtask

    task automatic test_quantum_expiry();
        exp_t e;
        for (int k = 1; k <= 45; k++) begin
            exp_q.push_back('{"expiry_pc", (k < 45) ? AW'(5 + k) : AW'(49)});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc || switch_req !== (k == 45)) begin
                n_err++;
                $display("FAIL %s: step %0d pc=%0d sreq=%0b want pc=%0d sreq=%0b",
                         e.tag, k, pc, switch_req, e.pc, (k == 45));
            end
        end
        jump = 1'b1; jump_addr = 12'h2AA; return_menu = 1'b1; halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{"switch_wait_hold", AW'(49)});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc || switch_req !== 1'b1 || halted !== 1'b0) begin
                n_err++;
                $display("FAIL %s: pc=%0d sreq=%0b halted=%0b want pc=%0d sreq=1 halted=0",
                         e.tag, pc, switch_req, halted, e.pc);
            end
        end
        jump = 1'b0; return_menu = 1'b0; halt = 1'b0;
        switch_ack = 1'b1; next_pid = 2'd1;
        exp_q.push_back('{"ack_invalid_ctx", AW'(427)});
        tick();
        switch_ack = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc || cur_pid !== 2'd1 || quantum_cnt !== 12'd0 || switch_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s: pc=%0d pid=%0d qc=%0d sreq=%0b want pc=%0d pid=1 qc=0 sreq=0",
                     e.tag, pc, cur_pid, quantum_cnt, switch_req, e.pc);
        end
    endtask

    task automatic test_restore();
        exp_t e;
        for (int k = 1; k <= 50; k++) begin
            exp_q.push_back('{"pid1_run", (k < 50) ? AW'(427 + k) : AW'(476)});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc || switch_req !== (k == 50)) begin
                n_err++;
                $display("FAIL %s: step %0d pc=%0d sreq=%0b want pc=%0d sreq=%0b",
                         e.tag, k, pc, switch_req, e.pc, (k == 50));
            end
        end
        switch_ack = 1'b1; next_pid = 2'd0;
        exp_q.push_back('{"ack_restore_pid0", AW'(50)});
        tick();
        switch_ack = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc || cur_pid !== 2'd0 || switch_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s: pc=%0d pid=%0d sreq=%0b want pc=%0d pid=0 sreq=0",
                     e.tag, pc, cur_pid, switch_req, e.pc);
        end
    endtask

    task automatic test_irq_eret();
        exp_t e;
        jump = 1'b1; jump_addr = 12'h100;
        exp_q.push_back('{"irq_jump", AW'(12'h100)});
        tick();
        jump = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", e.tag, pc, e.pc);
        end
        irq = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back('{"irq_kernel_pc", AW'(k)});
            tick();
            irq = 1'b0;
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc || kernel_mode !== 1'b1 || quantum_cnt !== 12'd2) begin
                n_err++;
                $display("FAIL %s: pc=%0d kern=%0b qc=%0d want pc=%0d kern=1 qc=2",
                         e.tag, pc, kernel_mode, quantum_cnt, e.pc);
            end
        end
        eret = 1'b1;
        exp_q.push_back('{"eret_pc", AW'(12'h101)});
        tick();
        eret = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc || kernel_mode !== 1'b0) begin
            n_err++;
            $display("FAIL %s: pc=%0h kern=%0b want pc=%0h kern=0", e.tag, pc, kernel_mode, e.pc);
        end
        exp_q.push_back('{"post_eret_pc", AW'(12'h102)});
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc || quantum_cnt !== 12'd3) begin
            n_err++;
            $display("FAIL %s: pc=%0h qc=%0d want pc=%0h qc=3", e.tag, pc, quantum_cnt, e.pc);
        end
    endtask

    task automatic test_halt_resume();
        exp_t e;
        jump = 1'b1; jump_addr = 12'd20; resume = 1'b1;
        exp_q.push_back('{"halt_jump", AW'(20)});
        tick();
        jump = 1'b0; halt = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", e.tag, pc, e.pc);
        end
        tick();
        halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back('{"halted_level_resume", AW'(20)});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc || halted !== 1'b1 || quantum_cnt !== 12'd5) begin
                n_err++;
                $display("FAIL %s: pc=%0d halted=%0b qc=%0d want pc=%0d halted=1 qc=5",
                         e.tag, pc, halted, quantum_cnt, e.pc);
            end
        end
        resume = 1'b0;
        tick();
        resume = 1'b1;
        exp_q.push_back('{"resume_edge", AW'(21)});
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc || halted !== 1'b0) begin
            n_err++;
            $display("FAIL %s: pc=%0d halted=%0b want pc=%0d halted=0", e.tag, pc, halted, e.pc);
        end
        resume = 1'b0;
    endtask

    task automatic test_irq_vs_expiry();
        exp_t e;
        for (int k = 0; k < 100 && quantum_cnt !== 12'd49; k++) tick();
        n_cmp++;
        if (quantum_cnt !== 12'd49) begin
            n_err++;
            $display("FAIL qc_reach_limit: qc=%0d want 49", quantum_cnt);
        end
        irq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{"irq_beats_expiry", AW'(k)});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc || kernel_mode !== 1'b1 || switch_req !== 1'b0) begin
                n_err++;
                $display("FAIL %s: pc=%0d kern=%0b sreq=%0b want pc=%0d kern=1 sreq=0",
                         e.tag, pc, kernel_mode, switch_req, e.pc);
            end
        end
        reset = 1'b1; irq = 1'b0;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({pc, cur_pid, switch_req, kernel_mode, quantum_cnt, halted} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_irq: pc=%0d pid=%0d sreq=%0b kern=%0b qc=%0d, required all zero",
                     pc, cur_pid, switch_req, kernel_mode, quantum_cnt);
        end
    endtask

    task automatic test_reset_clears_ctx();
        exp_t e;
        for (int k = 1; k <= 50; k++) begin
            exp_q.push_back('{"post_reset_run", (k < 50) ? AW'(k) : AW'(49)});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc || switch_req !== (k == 50)) begin
                n_err++;
                $display("FAIL %s: step %0d pc=%0d sreq=%0b want pc=%0d sreq=%0b",
                         e.tag, k, pc, switch_req, e.pc, (k == 50));
            end
        end
        switch_ack = 1'b1; next_pid = 2'd1;
        exp_q.push_back('{"ctx_cleared_by_reset", AW'(427)});
        tick();
        switch_ack = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (pc !== e.pc || cur_pid !== 2'd1) begin
            n_err++;
            $display("FAIL %s: pc=%0d pid=%0d want pc=%0d pid=1", e.tag, pc, cur_pid, e.pc);
        end
    endtask

    task automatic test_wrap_menu();
        exp_t   e;
        logic [AW-1:0] tgt [4];
        logic [3:0]    jmp;
        tgt = '{12'h3FF, 12'h400, 12'hFFF, 12'h000};
        jmp = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            jump = jmp[k]; jump_addr = tgt[k];
            exp_q.push_back('{"jump_wrap", tgt[k]});
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc) begin
                n_err++;
                $display("FAIL %s: step %0d got %0h want %0h", e.tag, k, pc, e.pc);
            end
        end
        jump = 1'b0; return_menu = 1'b1;
        exp_q.push_back('{"return_menu", AW'(34)});
        tick();
        return_menu = 1'b0;
        exp_q.push_back('{"after_menu", AW'(35)});
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e.pc) begin
                n_err++;
                $display("FAIL %s: got %0d want %0d", e.tag, pc, e.pc);
            end
            if (k == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_quantum_expiry();
        test_restore();
        test_irq_eret();
        test_halt_resume();
        test_irq_vs_expiry();
        test_reset_clears_ctx();
        test_wrap_menu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
